// File: rtl/register_dump_reader_pkg.sv
// Shared types and width defaults for the register-file dump reader.
package register_dump_reader_pkg;

    localparam int unsigned DEF_WORD_LENGTH_32 = 32;
    localparam int unsigned DEF_WORD_LENGTH_5  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/register_dump_reader_dump_index_counter.sv
// Register index counter: loads the first dumped index, steps once per accepted word.
module dump_index_counter #(
    parameter int unsigned W         = 5,
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_inc,
    output logic [W-1:0] o_index,
    output logic         o_last_c
);

    logic [W-1:0] r_index;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index <= '0;
        end else if (i_load) begin
            r_index <= W'(FIRST_REG);
        end else if (i_inc) begin
            r_index <= r_index + W'(1);
        end
    end

    assign o_index  = r_index;
    assign o_last_c = (r_index == W'(LAST_REG));

endmodule

// File: rtl/register_dump_reader.sv
// Debug read-out engine: walks register file entries FIRST_REG..LAST_REG and
// streams each word with its index over a valid/ready interface.
module register_dump_reader
    import register_dump_reader_pkg::*;
#(
    parameter int unsigned WORD_LENGTH_32 = DEF_WORD_LENGTH_32,
    parameter int unsigned WORD_LENGTH_5  = DEF_WORD_LENGTH_5,
    parameter int unsigned FIRST_REG      = 0,
    parameter int unsigned LAST_REG       = 31
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    output logic [WORD_LENGTH_5-1:0]  Read_reg,
    input  logic [WORD_LENGTH_32-1:0] Read_data,
    output logic [WORD_LENGTH_32-1:0] dump_data,
    output logic [WORD_LENGTH_5-1:0]  dump_index,
    output logic                      dump_valid,
    input  logic                      dump_ready,
    output logic                      busy,
    output logic                      done
);

    state_e                      r_state;
    logic [WORD_LENGTH_32-1:0]   r_dump_data;
    logic [WORD_LENGTH_5-1:0]    r_dump_index;
    logic                        r_dump_valid;
    logic                        r_busy;
    logic                        r_done;

    logic [WORD_LENGTH_5-1:0]    w_index;
    logic                        w_last;
    logic                        w_load;
    logic                        w_inc;

    // Exit compare happens before the increment, so the counter never wraps past LAST_REG.
    assign w_load = (r_state == ST_IDLE) && start && !abort;
    assign w_inc  = (r_state == ST_SEND) && dump_ready && !abort && !w_last;

    dump_index_counter #(
        .W         (WORD_LENGTH_5),
        .FIRST_REG (FIRST_REG),
        .LAST_REG  (LAST_REG)
    ) u_dump_index_counter (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_inc    (w_inc),
        .o_index  (w_index),
        .o_last_c (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_dump_data  <= '0;
            r_dump_index <= '0;
            r_dump_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_state <= ST_READ;
                        r_busy  <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_dump_data  <= Read_data;
                        r_dump_index <= w_index;
                        r_dump_valid <= 1'b1;
                        r_state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // An aborted word may still be accepted, but nothing follows it.
                    if (abort) begin
                        r_dump_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else if (dump_ready) begin
                        r_dump_valid <= 1'b0;
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Read_reg   = w_index;
    assign dump_data  = r_dump_data;
    assign dump_index = r_dump_index;
    assign dump_valid = r_dump_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: doc/register_dump_reader.md
Name: register_dump_reader

Overview:
Debug read-out engine for the multicycle MIPS register file. It owns one read port of the register file: a read-address output and a read-data input. On a start request it reads registers FIRST_REG..LAST_REG in ascending order. Each word is streamed out on a valid/ready interface with its register index. It is the reader counterpart of the register file write path and is used by the debug/test harness to dump architectural state.

Parameters:
WORD_LENGTH_32, 32, data width of register file words and of the dump stream
WORD_LENGTH_5, 5, register address width
FIRST_REG, 0, first register index dumped; FIRST_REG <= LAST_REG required
LAST_REG, 31, last register index dumped; must be < 2**WORD_LENGTH_5

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a dump; sampled only in IDLE
abort  input  1  synchronous cancel of a dump in progress
Read_reg  output  WORD_LENGTH_5  register file read address
Read_data  input  WORD_LENGTH_32  register file read data (combinational from Read_reg)
dump_data  output  WORD_LENGTH_32  captured register value
dump_index  output  WORD_LENGTH_5  register index of dump_data
dump_valid  output  1  dump_data/dump_index are valid
dump_ready  input  1  consumer accepts the current word
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Interface rule: one clock, clk. reset is asynchronous and active-high.
- Reset forces state IDLE and clears all registered outputs: Read_reg=0, dump_data=0, dump_index=0, dump_valid=0, busy=0, done=0. Reset takes effect immediately, including mid-dump; no partial word is emitted after reset.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- Index counter: WORD_LENGTH_5 bits. It loads FIRST_REG on start and increments by 1 per accepted word. Read_reg always equals the counter.
- FSM states and transitions:
  - IDLE: if start=1 and abort=0, load index=FIRST_REG and go to READ. Otherwise stay.
  - READ: one cycle with Read_reg stable. At the cycle end, dump_data<=Read_data, dump_index<=index, and state goes to SEND.
  - SEND: dump_valid=1. dump_data and dump_index are held stable until accepted. On dump_ready=1: if index==LAST_REG go to DONE; else index<=index+1 and go to READ.
  - DONE: done=1 for exactly one cycle, then IDLE.
- abort=1 in READ or SEND goes to IDLE next cycle with dump_valid=0. A word presented in the same cycle as abort is treated as accepted if dump_ready=1, but no further words follow and done is not pulsed. abort in IDLE or DONE has no effect beyond suppressing start.
- start is ignored while busy=1, including in DONE. A new dump can begin at the earliest on the cycle after DONE.
- Timing:
  - Throughput is 2 cycles per word with dump_ready tied high.
  - A full 32-register dump takes 1 (start) + 64 + 1 (DONE) = 66 cycles from start to done, inclusive.
  - The first dump_valid appears 2 cycles after start is sampled.
- Counter boundary: with LAST_REG=31 the counter never wraps, because the exit compare precedes the increment. When FIRST_REG==LAST_REG, exactly one word is dumped.
- dump_valid must never drop without a handshake, except on abort or reset. dump_data must not change while dump_valid=1 and dump_ready=0.

Decomposition:
- Shared package/header holds the state encodings (IDLE, READ, SEND, DONE; 2-bit) and the WORD_LENGTH_32/WORD_LENGTH_5 defaults.
- One natural sub-module, dump_index_counter. It is a WORD_LENGTH_5 register with load, increment and async reset, and outputs the index and last-flag (index==LAST_REG).
- Top level holds the FSM and the output capture register.

Test Plan:
1. Preload the register file with reg[i]=0xA5A50000+i, tie dump_ready=1 and pulse start -> 32 words in order, indices 0..31, data 0xA5A50000..0xA5A5001F, one word every 2 cycles, and done high at cycle 66 for one cycle.
2. Backpressure with dump_ready low for 5 cycles on word 7 -> dump_valid held, dump_index=7 and dump_data=0xA5A50007 stable throughout; no skipped or duplicated indices afterward.
3. Assert abort while SEND of index 12 with dump_ready=0 -> IDLE next cycle, dump_valid=0, busy=0, no done pulse; a new start then restarts at index 0.
4. Assert reset asynchronously (mid-cycle) during READ of index 20 -> all outputs 0 immediately; after release, the block is in IDLE and ignores dump_ready.
5. Pulse start while busy and during DONE -> ignored, no second dump. Set FIRST_REG=LAST_REG=5 -> exactly one word (index 5) followed by done.
